// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   EX-stage branch/jump resolver. On an accepted instruction it computes
//   the target, evaluates the branch condition and, for a taken and aligned
//   target, presents a registered PC redirect to fetch. Once fetch accepts
//   the redirect, the younger stages are flushed for FLUSH_CYCLES cycles.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready instruction handshake (in_ready depends on state only)
//   is_branch/is_jal/is_jalr, funct3
//                     one-hot instruction class and branch condition select
//   pc, imm_shl1, imm_i, rs1_data, rs2_data
//                     instruction PC, B/J offset (already <<1), I offset, operands
//   redirect_valid/redirect_ready/redirect_pc
//                     registered redirect request to fetch
//   link_data         pc+4 of the last accepted JAL/JALR
//   flush             squash IF/ID while high
//   misaligned        1-cycle pulse: taken target not word aligned, dropped
//   illegal_br        1-cycle pulse: branch with reserved funct3 (010/011)
//   taken_count       number of redirects accepted by fetch (wraps)
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm_shl1,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  link_data,
    output logic             flush,
    output logic             misaligned,
    output logic             illegal_br,
    output logic [CNT_W-1:0] taken_count
);

    localparam int FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_t;

    state_t state, state_next;

    logic [FCW-1:0]  flush_cnt;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            accept;
    logic            cond_taken;
    logic            taken;
    logic            aligned;
    logic            reserved_f3;
    logic            handshake;

    assign accept    = in_valid & in_ready;
    assign handshake = (state == REDIRECT) & redirect_ready;

    // JALR clears bit 0 of the sum; bit 1 can still be set and is caught
    // by the alignment check below.
    assign jalr_sum = rs1_data + imm_i;
    assign target   = is_jalr ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0})
                              : (pc + imm_shl1);
    assign aligned  = (target[1:0] == 2'b00);

    assign reserved_f3 = (funct3 == 3'b010) || (funct3 == 3'b011);

    always_comb begin
        cond_taken = 1'b0;
        case (funct3)
            3'b000:  cond_taken = (rs1_data == rs2_data);
            3'b001:  cond_taken = (rs1_data != rs2_data);
            3'b100:  cond_taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  cond_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  cond_taken = (rs1_data <  rs2_data);
            3'b111:  cond_taken = (rs1_data >= rs2_data);
            default: cond_taken = 1'b0;
        endcase
    end

    assign taken = is_jal | is_jalr | (is_branch & cond_taken);

    // Handshake outputs are pure functions of state, so there is no
    // combinational in_valid -> in_ready or redirect_ready -> in_ready path.
    assign in_ready       = (state == IDLE);
    assign redirect_valid = (state == REDIRECT);
    assign flush          = (state == FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && taken && aligned) begin
                    state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == FCW'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_pc <= '0;
            link_data   <= '0;
            misaligned  <= 1'b0;
            illegal_br  <= 1'b0;
            taken_count <= '0;
            flush_cnt   <= '0;
        end else begin
            misaligned <= accept & taken & ~aligned;
            illegal_br <= accept & is_branch & reserved_f3;

            if (accept && taken && aligned) begin
                redirect_pc <= target;
            end

            if (accept && (is_jal || is_jalr)) begin
                link_data <= pc + XLEN'(4);
            end

            if (handshake) begin
                taken_count <= taken_count + CNT_W'(1);
                flush_cnt   <= FCW'(FLUSH_CYCLES);
            end else if (state == FLUSH) begin
                flush_cnt <= flush_cnt - FCW'(1);
            end
        end
    end

endmodule
